// File: rtl/mux_sel_scanner.sv
// rtl/mux_sel_scanner.sv - channel sequencer driving a 4:1 mux select and capturing its output
module mux_sel_scanner #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 start,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [3:0]           mask,
    input  logic [3:0]           y_in,
    output logic [1:0]           sel,
    output logic                 busy,
    output logic [3:0]           cap_data,
    output logic [1:0]           cap_ch,
    output logic                 cap_valid,
    output logic                 sweep_done
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);

    state_t               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           sel_q, sel_d;
    logic                 busy_q, busy_d;
    logic [3:0]           cap_data_q, cap_data_d;
    logic [1:0]           cap_ch_q, cap_ch_d;
    logic                 cap_valid_q, cap_valid_d;
    logic                 sweep_done_q, sweep_done_d;
    logic [2:0]           lowest, above;

    // Returns {found, index} of the lowest set bit of m at or above lo.
    function automatic logic [2:0] first_from(input logic [3:0] m, input logic [2:0] lo);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (3'(i) >= lo)) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    assign lowest = first_from(mask, 3'd0);
    assign above  = first_from(mask, {1'b0, sel_q} + 3'd1);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        busy_d       = busy_q;
        cap_data_d   = cap_data_q;
        cap_ch_d     = cap_ch_q;
        cap_valid_d  = 1'b0;
        sweep_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && (mask != 4'd0) && (!mode || start)) begin
                    state_d = SCAN;
                    mode_d  = mode;
                    sel_d   = lowest[1:0];
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SCAN: begin
                if (!en) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q >= div) begin
                    cnt_d       = '0;
                    cap_data_d  = y_in;
                    cap_ch_d    = sel_q;
                    cap_valid_d = 1'b1;
                    if (mask == 4'd0) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else if (above[2]) begin
                        sel_d = above[1:0];
                    end else if (mode_q) begin
                        // No enabled channel above: single sweep is finished, sel holds
                        state_d      = IDLE;
                        busy_d       = 1'b0;
                        sweep_done_d = 1'b1;
                    end else begin
                        sel_d = lowest[1:0];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            cnt_q        <= '0;
            sel_q        <= 2'd0;
            busy_q       <= 1'b0;
            cap_data_q   <= 4'd0;
            cap_ch_q     <= 2'd0;
            cap_valid_q  <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            busy_q       <= busy_d;
            cap_data_q   <= cap_data_d;
            cap_ch_q     <= cap_ch_d;
            cap_valid_q  <= cap_valid_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign sel        = sel_q;
    assign busy       = busy_q;
    assign cap_data   = cap_data_q;
    assign cap_ch     = cap_ch_q;
    assign cap_valid  = cap_valid_q;
    assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// tb/tb_mux_sel_scanner.sv - directed self-checking bench for mux_sel_scanner
module tb_mux_sel_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, mode, start;
    logic [7:0] div;
    logic [3:0] mask;
    logic [3:0] y_in;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] cap_data;
    logic [1:0] cap_ch;
    logic       cap_valid;
    logic       sweep_done;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Mux environment: a=1, b=2, c=4, d=8
    assign y_in = (sel == 2'd0) ? 4'b0001 :
                  (sel == 2'd1) ? 4'b0010 :
                  (sel == 2'd2) ? 4'b0100 : 4'b1000;

    mux_sel_scanner #(.DIV_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .start(start),
        .div(div), .mask(mask), .y_in(y_in), .sel(sel), .busy(busy),
        .cap_data(cap_data), .cap_ch(cap_ch), .cap_valid(cap_valid),
        .sweep_done(sweep_done)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all0(input string tag);
        chk({tag, ".sel"}, 8'(sel), 8'd0);
        chk({tag, ".busy"}, 8'(busy), 8'd0);
        chk({tag, ".cap_data"}, 8'(cap_data), 8'd0);
        chk({tag, ".cap_ch"}, 8'(cap_ch), 8'd0);
        chk({tag, ".cap_valid"}, 8'(cap_valid), 8'd0);
        chk({tag, ".sweep_done"}, 8'(sweep_done), 8'd0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; start = 1'b0; div = 8'd0; mask = 4'd0;
        #2;
        chk_all0("reset");
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle.busy", 8'(busy), 8'd0);

        // 1: continuous full scan, div=3
        mode = 1'b0; div = 8'd3; mask = 4'b1111; en = 1'b1;
        tick();
        chk("t1.entry.busy", 8'(busy), 8'd1);
        chk("t1.entry.sel", 8'(sel), 8'd0);
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 3; j++) begin
                tick();
                chk("t1.dwell.sel", 8'(sel), 8'(k % 4));
                chk("t1.dwell.cap_valid", 8'(cap_valid), 8'd0);
            end
            tick();
            chk("t1.adv.cap_valid", 8'(cap_valid), 8'd1);
            chk("t1.adv.cap_data", 8'(cap_data), 8'(1 << (k % 4)));
            chk("t1.adv.cap_ch", 8'(cap_ch), 8'(k % 4));
            chk("t1.adv.sel", 8'(sel), 8'((k + 1) % 4));
            chk("t1.adv.sweep_done", 8'(sweep_done), 8'd0);
        end
        // 4a: abort mid-dwell
        tick();
        en = 1'b0;
        tick();
        chk("t4.abort.busy", 8'(busy), 8'd0);
        chk("t4.abort.cap_valid", 8'(cap_valid), 8'd0);
        chk("t4.abort.sel", 8'(sel), 8'd1);
        tick();
        chk("t4.abort.idle", 8'(busy), 8'd0);

        // 2: single sweep, sparse mask, div=1
        mode = 1'b1; div = 8'd1; mask = 4'b1010; en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2.entry.busy", 8'(busy), 8'd1);
        chk("t2.entry.sel", 8'(sel), 8'd1);
        tick();
        chk("t2.dwell1.sel", 8'(sel), 8'd1);
        chk("t2.dwell1.cap_valid", 8'(cap_valid), 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2.adv1.cap_valid", 8'(cap_valid), 8'd1);
        chk("t2.adv1.cap_data", 8'(cap_data), 8'd2);
        chk("t2.adv1.cap_ch", 8'(cap_ch), 8'd1);
        chk("t2.adv1.sel", 8'(sel), 8'd3);
        chk("t2.adv1.sweep_done", 8'(sweep_done), 8'd0);
        tick();
        chk("t2.dwell3.sel", 8'(sel), 8'd3);
        chk("t2.dwell3.busy", 8'(busy), 8'd1);
        tick();
        chk("t2.adv3.cap_valid", 8'(cap_valid), 8'd1);
        chk("t2.adv3.cap_data", 8'(cap_data), 8'd8);
        chk("t2.adv3.cap_ch", 8'(cap_ch), 8'd3);
        chk("t2.adv3.sweep_done", 8'(sweep_done), 8'd1);
        chk("t2.adv3.busy", 8'(busy), 8'd0);
        chk("t2.adv3.sel", 8'(sel), 8'd3);
        tick();
        chk("t2.post.busy", 8'(busy), 8'd0);
        chk("t2.post.sweep_done", 8'(sweep_done), 8'd0);
        chk("t2.post.sel", 8'(sel), 8'd3);

        // 3: minimum dwell, continuous, mask 0101
        mode = 1'b0; div = 8'd0; mask = 4'b0101;
        tick();
        chk("t3.entry.sel", 8'(sel), 8'd0);
        chk("t3.entry.busy", 8'(busy), 8'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t3.cap_valid", 8'(cap_valid), 8'd1);
            chk("t3.cap_data", 8'(cap_data), (k % 2 == 0) ? 8'd1 : 8'd4);
            chk("t3.sel", 8'(sel), (k % 2 == 0) ? 8'd2 : 8'd0);
        end
        en = 1'b0;
        tick();
        chk("t3.stop.busy", 8'(busy), 8'd0);

        // 4b: empty mask blocks start
        mode = 1'b1; mask = 4'd0; start = 1'b1; en = 1'b1;
        tick();
        chk("t4.empty.busy", 8'(busy), 8'd0);
        tick();
        start = 1'b0;
        chk("t4.empty.busy2", 8'(busy), 8'd0);

        // 5a: mask edit while on channel 1
        mode = 1'b0; mask = 4'b1111; div = 8'd1;
        tick();
        chk("t5.entry.sel", 8'(sel), 8'd0);
        tick();
        tick();
        chk("t5.adv0.sel", 8'(sel), 8'd1);
        mask = 4'b1001;
        tick();
        tick();
        chk("t5.adv1.cap_valid", 8'(cap_valid), 8'd1);
        chk("t5.adv1.cap_data", 8'(cap_data), 8'd2);
        chk("t5.adv1.cap_ch", 8'(cap_ch), 8'd1);
        chk("t5.adv1.sel", 8'(sel), 8'd3);
        // 5b: div drop 7 -> 0 mid-dwell
        div = 8'd7;
        tick();
        tick();
        chk("t5.div7.cap_valid", 8'(cap_valid), 8'd0);
        div = 8'd0;
        tick();
        chk("t5.divdrop.cap_valid", 8'(cap_valid), 8'd1);
        chk("t5.divdrop.cap_data", 8'(cap_data), 8'd8);
        chk("t5.divdrop.sel", 8'(sel), 8'd0);
        // mask cleared at an advance edge: capture, then idle, no sweep_done
        mask = 4'd0;
        tick();
        chk("t5.mask0.cap_valid", 8'(cap_valid), 8'd1);
        chk("t5.mask0.cap_data", 8'(cap_data), 8'd1);
        chk("t5.mask0.busy", 8'(busy), 8'd0);
        chk("t5.mask0.sweep_done", 8'(sweep_done), 8'd0);

        // 6: async reset between edges during SCAN
        mask = 4'b1111; div = 8'd3;
        tick();
        tick();
        chk("t6.scan.busy", 8'(busy), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all0("t6.async");
        en = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("t6.release.busy", 8'(busy), 8'd0);
        en = 1'b1;
        tick();
        chk("t6.reentry.busy", 8'(busy), 8'd1);
        chk("t6.reentry.sel", 8'(sel), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
